// File: rtl/bram_fifo_pkg.sv
// Shared helpers for the block-RAM FIFO: level-counter sizing and depth validation.
package bram_fifo_pkg;

  // Level counter must represent 0..DEPTH inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/bram_sdp_ram.sv
// Simple-dual-port RAM, one write port and a registered read port with read enable.
// Output holds its value while rd_en_i is low, matching SB_RAM40_4K RCLKE behaviour.
module bram_sdp_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/bram_fifo.sv
// First-word-fall-through FIFO on inferred block RAM with a registered read port.
// Optional overflow statistics enabled by defining BRAM_FIFO_OVERFLOW_STATS_EN.
module bram_fifo
  import bram_fifo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int AFULL_LEVEL = DEPTH - 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   level,
  output logic              almost_full
`ifdef BRAM_FIFO_OVERFLOW_STATS_EN
  ,
  output logic              overflow,
  output logic [15:0]       drop_count
`endif
);

  localparam int LVL_W = level_width(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AFULL_LVL = LVL_W'(AFULL_LEVEL);

  if (!is_pow2(DEPTH) || DEPTH < 4 || DEPTH > 4096) begin : g_bad_depth
    $error("bram_fifo: DEPTH must be a power of two in 4..4096");
  end

  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d, ram_cnt;
  logic              inflight_q, out_valid_q, almost_full_q;
  logic [WIDTH-1:0]  out_data_q, ram_rd_data;
  logic              push, pop, load, issue;

  // The RAM read register doubles as a one-word skid stage: a word read
  // there waits until the output register is free or being popped.
  assign in_ready = (level_q != FULL_LVL);
  assign push     = in_valid && in_ready;
  assign pop      = out_valid_q && out_ready;
  assign load     = inflight_q && (!out_valid_q || pop);
  assign ram_cnt  = level_q - LVL_W'(inflight_q) - LVL_W'(out_valid_q);
  assign issue    = (ram_cnt != '0) && (!inflight_q || load);

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  bram_sdp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (push && resetn),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (in_data),
    .rd_en_i   (issue && resetn),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (ram_rd_data)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      inflight_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      almost_full_q <= 1'b0;
    end else begin
      if (push)  wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (issue) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      level_q       <= level_d;
      almost_full_q <= (level_d >= AFULL_LVL);
      if (issue)     inflight_q <= 1'b1;
      else if (load) inflight_q <= 1'b0;
      if (load) begin
        out_data_q  <= ram_rd_data;
        out_valid_q <= 1'b1;
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign level       = level_q;
  assign almost_full = almost_full_q;

`ifdef BRAM_FIFO_OVERFLOW_STATS_EN
  logic        overflow_q;
  logic [15:0] drop_count_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else if (in_valid && !in_ready) begin
      overflow_q <= 1'b1;
      if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_bram_fifo.sv
// Scoreboard bench for bram_fifo (WIDTH=16, DEPTH=256).
module tb_bram_fifo;

  localparam int DEPTH = 256;
  localparam int AFULL = DEPTH - 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  level;
  logic        almost_full;
`ifdef BRAM_FIFO_OVERFLOW_STATS_EN
  logic        overflow;
  logic [15:0] drop_count;
`endif

  int vectors = 0;
  int miscompares = 0;
  int mlevel = 0;
  int total_pushes = 0;
  logic [15:0] sb[$];

  bram_fifo #(.WIDTH(16), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .level       (level),
    .almost_full (almost_full)
`ifdef BRAM_FIFO_OVERFLOW_STATS_EN
    ,
    .overflow    (overflow),
    .drop_count  (drop_count)
`endif
  );

  always #5 clk = ~clk;

  // Drive one cycle; record accepted pushes in the scoreboard and report the head taken.
  task automatic tick(input logic iv, input logic [15:0] d, input logic ordy,
                      output logic pushed, output logic popped, output logic [15:0] pdata);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    pushed = iv && in_ready;
    popped = out_valid && ordy;
    pdata  = out_data;
    if (pushed) begin
      sb.push_back(d);
      total_pushes++;
    end
    mlevel = mlevel + int'(pushed) - int'(popped);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (level !== 9'd0) begin miscompares++; $display("FAIL reset_level got %0d want 0", level); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++; if (almost_full !== 1'b0) begin miscompares++; $display("FAIL reset_almost_full got %b want 0", almost_full); end
    vectors++; if (out_data !== 16'h0) begin miscompares++; $display("FAIL reset_out_data got %h want 0000", out_data); end
    sb.delete(); mlevel = 0;
  endtask

  task automatic test_latency();
    logic pu, po; logic [15:0] pd, ex;
    tick(1'b1, 16'hA5A5, 1'b0, pu, po, pd);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL lat_T got %b want 0", out_valid); end
    tick(1'b0, 16'h0, 1'b0, pu, po, pd);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL lat_T1 got %b want 0", out_valid); end
    tick(1'b0, 16'h0, 1'b0, pu, po, pd);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL lat_T2 got %b want 1", out_valid); end
    vectors++; if (out_data !== 16'hA5A5) begin miscompares++; $display("FAIL lat_data got %h want a5a5", out_data); end
    vectors++; if (level !== 9'd1) begin miscompares++; $display("FAIL lat_level got %0d want 1", level); end
    tick(1'b0, 16'h0, 1'b1, pu, po, pd);
    ex = sb.pop_front();
    vectors++; if (!po || pd !== ex) begin miscompares++; $display("FAIL lat_pop got %b/%h want 1/%h", po, pd, ex); end
    vectors++; if (out_valid !== 1'b0 || level !== 9'd0) begin miscompares++; $display("FAIL lat_empty got %b/%0d want 0/0", out_valid, level); end
  endtask

  task automatic test_fill_and_drain();
    logic pu, po; logic [15:0] pd, ex;
    int cycles;
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b1, 16'(i), 1'b0, pu, po, pd);
      vectors++; if (pu !== 1'b1) begin miscompares++; $display("FAIL fill_accept idx %0d got %b want 1", i, pu); end
      vectors++; if (almost_full !== (mlevel >= AFULL)) begin miscompares++; $display("FAIL fill_afull lvl %0d got %b want %b", mlevel, almost_full, mlevel >= AFULL); end
    end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready got %b want 0", in_ready); end
    vectors++; if (level !== 9'd256) begin miscompares++; $display("FAIL full_level got %0d want 256", level); end
    // Push and pop together while full: only the pop happens.
    tick(1'b1, 16'hBEEF, 1'b1, pu, po, pd);
    ex = sb.pop_front();
    vectors++; if (pu !== 1'b0 || po !== 1'b1 || pd !== ex) begin miscompares++; $display("FAIL full_pushpop got %b/%b/%h want 0/1/%h", pu, po, pd, ex); end
    vectors++; if (level !== 9'd255) begin miscompares++; $display("FAIL full_pushpop_level got %0d want 255", level); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL full_pushpop_ready got %b want 1", in_ready); end
    cycles = 0;
    while (sb.size() > 0 && cycles < 400) begin
      tick(1'b0, 16'h0, 1'b1, pu, po, pd);
      cycles++;
      if (po) begin
        ex = sb.pop_front();
        vectors++; if (pd !== ex) begin miscompares++; $display("FAIL drain_data got %h want %h", pd, ex); end
      end
    end
    vectors++; if (cycles != 255) begin miscompares++; $display("FAIL drain_rate got %0d cycles want 255", cycles); end
    vectors++; if (level !== 9'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL drain_empty got %0d/%b want 0/0", level, out_valid); end
  endtask

  task automatic test_random();
    logic pu, po; logic [15:0] pd, ex;
    logic iv, ordy;
    int start_pushes, guard;
    start_pushes = total_pushes;
    for (int c = 0; c < 10000; c++) begin
      iv   = ($urandom_range(0, 7) != 0);
      ordy = ((c / 700) % 2 == 0) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 1) != 0);
      vectors++; if (in_ready !== (mlevel != DEPTH)) begin miscompares++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", c, in_ready, mlevel != DEPTH); end
      tick(iv, 16'($urandom), ordy, pu, po, pd);
      if (po) begin
        if (sb.size() == 0) begin
          vectors++; miscompares++; $display("FAIL rnd_spurious cyc %0d got %h want nothing", c, pd);
        end else begin
          ex = sb.pop_front();
          vectors++; if (pd !== ex) begin miscompares++; $display("FAIL rnd_data cyc %0d got %h want %h", c, pd, ex); end
        end
      end
      vectors++; if (level !== 9'(mlevel)) begin miscompares++; $display("FAIL rnd_level cyc %0d got %0d want %0d", c, level, mlevel); end
      vectors++; if (almost_full !== (mlevel >= AFULL)) begin miscompares++; $display("FAIL rnd_afull cyc %0d got %b want %b", c, almost_full, mlevel >= AFULL); end
    end
    vectors++; if (total_pushes - start_pushes < 20 * DEPTH) begin miscompares++; $display("FAIL rnd_wraps got %0d pushes want >= %0d", total_pushes - start_pushes, 20 * DEPTH); end
    guard = 0;
    while ((sb.size() > 0 || out_valid) && guard < 600) begin
      tick(1'b0, 16'h0, 1'b1, pu, po, pd);
      guard++;
      if (po) begin
        ex = (sb.size() > 0) ? sb.pop_front() : ~pd;
        vectors++; if (pd !== ex) begin miscompares++; $display("FAIL rnd_drain got %h want %h", pd, ex); end
      end
    end
    vectors++; if (sb.size() != 0 || level !== 9'd0) begin miscompares++; $display("FAIL rnd_final got %0d left lvl %0d want 0/0", sb.size(), level); end
  endtask

  task automatic test_reset_midop();
    logic pu, po; logic [15:0] pd;
    for (int i = 0; i < 100; i++) tick(1'b1, 16'(16'h4000 + i), 1'b0, pu, po, pd);
    in_valid = 1'b0; out_ready = 1'b1; resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1; out_ready = 1'b0;
    sb.delete(); mlevel = 0;
    vectors++; if (out_valid !== 1'b0 || level !== 9'd0) begin miscompares++; $display("FAIL midrst_state got %b/%0d want 0/0", out_valid, level); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready got %b want 1", in_ready); end
    tick(1'b0, 16'h0, 1'b0, pu, po, pd);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_residual got %b want 0", out_valid); end
    tick(1'b1, 16'h1234, 1'b0, pu, po, pd);
    tick(1'b0, 16'h0, 1'b0, pu, po, pd);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_T1 got %b want 0", out_valid); end
    tick(1'b0, 16'h0, 1'b0, pu, po, pd);
    vectors++; if (out_valid !== 1'b1 || out_data !== 16'h1234) begin miscompares++; $display("FAIL midrst_fresh got %b/%h want 1/1234", out_valid, out_data); end
    tick(1'b0, 16'h0, 1'b1, pu, po, pd);
    void'(sb.pop_front());
    vectors++; if (level !== 9'd0) begin miscompares++; $display("FAIL midrst_drain got %0d want 0", level); end
  endtask

`ifdef BRAM_FIFO_OVERFLOW_STATS_EN
  task automatic test_overflow();
    logic pu, po; logic [15:0] pd;
    int guard;
    for (int i = 0; i < DEPTH; i++) tick(1'b1, 16'(i), 1'b0, pu, po, pd);
    vectors++; if (overflow !== 1'b0 || drop_count !== 16'd0) begin miscompares++; $display("FAIL ovf_pre got %b/%0d want 0/0", overflow, drop_count); end
    for (int i = 0; i < 5; i++) tick(1'b1, 16'hDEAD, 1'b0, pu, po, pd);
    vectors++; if (drop_count !== 16'd5 || overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_count got %b/%0d want 1/5", overflow, drop_count); end
    guard = 0;
    while ((sb.size() > 0 || out_valid) && guard < 600) begin
      tick(1'b0, 16'h0, 1'b1, pu, po, pd);
      if (po && sb.size() > 0) void'(sb.pop_front());
      guard++;
    end
    vectors++; if (drop_count !== 16'd5 || overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %b/%0d want 1/5", overflow, drop_count); end
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    sb.delete(); mlevel = 0;
    vectors++; if (drop_count !== 16'd0 || overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_reset got %b/%0d want 0/0", overflow, drop_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_fill_and_drain();
    test_random();
    test_reset_midop();
`ifdef BRAM_FIFO_OVERFLOW_STATS_EN
    test_overflow();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
